// File: rtl/fc_pkg.sv
// Shared FC port definitions: RX port states, primitive ordered-set words
// and the state-to-primitive lookup used by the transmit scheduler.
package fc;

    typedef enum logic [3:0] {
        AC  = 4'd0,
        LR1 = 4'd1,
        LR2 = 4'd2,
        LR3 = 4'd3,
        LF1 = 4'd4,
        LF2 = 4'd5,
        OL1 = 4'd6,
        OL2 = 4'd7,
        OL3 = 4'd8
    } state_t;

    localparam logic [31:0] IDLE_WORD = 32'hBC95B5B5;
    localparam logic [31:0] OLS_WORD  = 32'hBC358A55;
    localparam logic [31:0] NOS_WORD  = 32'hBC55BF45;
    localparam logic [31:0] LR_WORD   = 32'hBC49BF49;
    localparam logic [31:0] LRR_WORD  = 32'hBC35BF49;
    localparam logic [3:0]  PRIM_K    = 4'b1000;

    function automatic logic [31:0] state_primitive(input state_t st);
        logic [31:0] w;
        case (st)
            OL1, LF1: w = OLS_WORD;
            OL2, LR1: w = LR_WORD;
            OL3, LF2: w = NOS_WORD;
            LR2:      w = LRR_WORD;
            LR3, AC:  w = IDLE_WORD;
            // unknown encodings fall back to Offline
            default:  w = OLS_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fc_tx_scheduler.sv
// FC transmit sequencer: primitive sequences, IDLE gap and frame pass-through.
// Define FC_TX_STATS_EN to add the frames_sent / frames_aborted counters.
module fc_tx_scheduler
    import fc::*;
#(
    parameter int MIN_IDLE = 6
`ifdef FC_TX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  state_t      state,
    input  logic        is_active,
    input  logic [31:0] frame_data,
    input  logic [3:0]  frame_datak,
    input  logic        frame_sop,
    input  logic        frame_eop,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_datak
`ifdef FC_TX_STATS_EN
    ,
    output logic [CNT_W-1:0] frames_sent,
    output logic [CNT_W-1:0] frames_aborted
`endif
);

    localparam int GW = $clog2(MIN_IDLE + 1);
    localparam logic [GW-1:0] GAP_FULL = GW'(MIN_IDLE);
    // the AC primitive is itself an IDLE, so Active entry needs one fewer
    localparam logic [GW-1:0] GAP_ENTRY = GW'(MIN_IDLE - 1);

    typedef enum logic [2:0] {
        S_PRIM,
        S_GAP,
        S_IDLE,
        S_FRAME,
        S_DROP
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [GW-1:0] gap_q, gap_d, gap_dec;
    logic [31:0]   data_q, data_d;
    logic [3:0]    datak_q, datak_d;
    logic          leave;
    logic          sent_inc, abort_inc;

    assign leave   = (state != AC);
    assign gap_dec = (gap_q == '0) ? '0 : gap_q - 1'b1;

    always_comb begin
        fsm_d       = fsm_q;
        gap_d       = gap_q;
        data_d      = IDLE_WORD;
        datak_d     = PRIM_K;
        frame_ready = 1'b0;
        sent_inc    = 1'b0;
        abort_inc   = 1'b0;
        unique case (fsm_q)
            S_PRIM: begin
                data_d = state_primitive(state);
                if (!leave) begin
                    fsm_d = S_GAP;
                    gap_d = GAP_ENTRY;
                end
            end
            S_GAP: begin
                gap_d = gap_dec;
                if (leave) begin
                    fsm_d = S_PRIM;
                end else if (gap_dec == '0 && is_active) begin
                    fsm_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (leave) begin
                    fsm_d = S_PRIM;
                end else if (!is_active) begin
                    fsm_d = S_GAP;
                    gap_d = '0;
                end else begin
                    frame_ready = frame_valid;
                    if (frame_valid && frame_sop) begin
                        data_d  = frame_data;
                        datak_d = frame_datak;
                        if (frame_eop) begin
                            fsm_d    = S_GAP;
                            gap_d    = GAP_FULL;
                            sent_inc = 1'b1;
                        end else begin
                            fsm_d = S_FRAME;
                        end
                    end else if (frame_valid) begin
                        abort_inc = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    data_d  = frame_data;
                    datak_d = frame_datak;
                end
                if (frame_valid && frame_eop) begin
                    fsm_d    = leave ? S_PRIM : S_GAP;
                    gap_d    = GAP_FULL;
                    sent_inc = 1'b1;
                end else if (leave) begin
                    fsm_d     = S_DROP;
                    abort_inc = 1'b1;
                end
            end
            S_DROP: begin
                data_d      = state_primitive(state);
                frame_ready = 1'b1;
                if (frame_valid && frame_eop) begin
                    fsm_d = S_PRIM;
                end
            end
            default: fsm_d = S_PRIM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= S_PRIM;
            gap_q   <= GAP_FULL;
            data_q  <= IDLE_WORD;
            datak_q <= PRIM_K;
        end else begin
            fsm_q   <= fsm_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            datak_q <= datak_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_datak = datak_q;

`ifdef FC_TX_STATS_EN
    logic [CNT_W-1:0] sent_q, abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_q  <= '0;
            abort_q <= '0;
        end else begin
            if (sent_inc) begin
                sent_q <= sent_q + 1'b1;
            end
            if (abort_inc) begin
                abort_q <= abort_q + 1'b1;
            end
        end
    end

    assign frames_sent    = sent_q;
    assign frames_aborted = abort_q;
`else
    logic stats_unused;
    assign stats_unused = sent_inc ^ abort_inc;
`endif

endmodule

// File: tb/tb_fc_tx_scheduler.sv
// Bench for fc_tx_scheduler: directed vectors, a spec-level lane model
// checked every cycle, and literal expectations for the key scenarios.
module tb_fc_tx_scheduler;
    import fc::*;

    localparam int MIN_GAP = 6;
    localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
    localparam logic [31:0] W_OLS  = 32'hBC358A55;
    localparam logic [31:0] W_LR   = 32'hBC49BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35BF49;
    localparam logic [31:0] W_NOS  = 32'hBC55BF45;
    localparam logic [3:0]  K_PRIM = 4'b1000;

    logic        clk = 1'b0;
    logic        reset_n;
    state_t      st;
    logic        is_active;
    logic [31:0] fd;
    logic [3:0]  fk;
    logic        fsop, feop, fv;
    logic        frame_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_datak;
`ifdef FC_TX_STATS_EN
    logic [15:0] frames_sent, frames_aborted;
`endif

    int checks = 0;
    int errors = 0;

    fc_tx_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (st),
        .is_active   (is_active),
        .frame_data  (fd),
        .frame_datak (fk),
        .frame_sop   (fsop),
        .frame_eop   (feop),
        .frame_valid (fv),
        .frame_ready (frame_ready),
        .tx_data     (tx_data),
        .tx_datak    (tx_datak)
`ifdef FC_TX_STATS_EN
        ,
        .frames_sent    (frames_sent),
        .frames_aborted (frames_aborted)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prim_of(input state_t s);
        logic [31:0] w;
        case (s)
            OL1, LF1: w = W_OLS;
            OL2, LR1: w = W_LR;
            OL3, LF2: w = W_NOS;
            LR2:      w = W_LRR;
            LR3, AC:  w = W_IDLE;
            default:  w = W_OLS;
        endcase
        return w;
    endfunction

    // Lane model: "up" = Active acknowledged, quiet = IDLEs since last frame
    logic        up, in_fr, drop, act_prev;
    int          quiet, m_sent, m_abort;
    logic [31:0] exp_tx;
    logic [3:0]  exp_k;
    logic        n_up, n_fr, n_drop, m_rdy, grant;
    int          n_quiet, n_sent, n_abort;
    logic [31:0] sel;
    logic [3:0]  selk;

    always_comb begin
        n_up    = up;
        n_fr    = in_fr;
        n_drop  = drop;
        n_quiet = quiet;
        n_sent  = m_sent;
        n_abort = m_abort;
        sel     = W_IDLE;
        selk    = K_PRIM;
        m_rdy   = 1'b0;
        grant   = up && !in_fr && !drop && st == AC && is_active &&
                  act_prev && quiet >= MIN_GAP;
        if (drop) begin
            sel   = prim_of(st);
            m_rdy = 1'b1;
            if (fv && feop) n_drop = 1'b0;
        end else if (!up) begin
            sel = prim_of(st);
            if (st == AC) begin
                n_up    = 1'b1;
                n_quiet = 1;
            end
        end else if (in_fr) begin
            m_rdy = 1'b1;
            if (fv) begin
                sel  = fd;
                selk = fk;
            end
            if (fv && feop) begin
                n_fr    = 1'b0;
                n_quiet = 0;
                n_sent  = m_sent + 1;
                if (st != AC) n_up = 1'b0;
            end else if (st != AC) begin
                n_fr    = 1'b0;
                n_drop  = 1'b1;
                n_abort = m_abort + 1;
                n_up    = 1'b0;
            end
        end else if (st != AC) begin
            n_up = 1'b0;
        end else if (grant) begin
            m_rdy = fv;
            if (fv && fsop) begin
                sel  = fd;
                selk = fk;
                if (feop) begin
                    n_quiet = 0;
                    n_sent  = m_sent + 1;
                end else begin
                    n_fr = 1'b1;
                end
            end else begin
                n_quiet = (quiet < 1000) ? quiet + 1 : quiet;
                if (fv) n_abort = m_abort + 1;
            end
        end else begin
            n_quiet = (quiet < 1000) ? quiet + 1 : quiet;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up <= 1'b0; in_fr <= 1'b0; drop <= 1'b0; act_prev <= 1'b0;
            quiet <= 0; m_sent <= 0; m_abort <= 0;
            exp_tx <= W_IDLE; exp_k <= K_PRIM;
        end else begin
            up <= n_up; in_fr <= n_fr; drop <= n_drop;
            act_prev <= is_active;
            quiet <= n_quiet; m_sent <= n_sent; m_abort <= n_abort;
            exp_tx <= sel; exp_k <= selk;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model-tx", 64'(tx_data), 64'(exp_tx));
            chk("model-k", 64'(tx_datak), 64'(exp_k));
            chk("model-ready", 64'(frame_ready), 64'(m_rdy));
`ifdef FC_TX_STATS_EN
            chk("model-sent", 64'(frames_sent), 64'(m_sent[15:0]));
            chk("model-abort", 64'(frames_aborted), 64'(m_abort[15:0]));
`endif
        end
    end

    // IDLE run length before each non-IDLE word, and drained-word leaks
    int run = 0, last_run = 0, leak = 0;
    always begin
        @(posedge clk);
        #1;
        if (tx_data == W_IDLE) run++;
        else begin
            last_run = run;
            run = 0;
        end
        if (tx_data >= 32'hD4D40002 && tx_data <= 32'hD4D40004) leak++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k,
                             input logic sop, input logic eop,
                             input logic [31:0] exp, input string nm,
                             output int waited);
        fd = d; fk = k; fsop = sop; feop = eop; fv = 1'b1;
        #1;
        waited = 0;
        while (!frame_ready && waited < 40) begin
            tick();
            waited++;
        end
        chk({nm, "-accept"}, 64'(frame_ready), 64'd1);
        tick();
        chk({nm, "-tx"}, 64'(tx_data), 64'(exp));
    endtask

    function automatic logic [3:0] kof(input int i, input int n);
        return (i == 0 || i == n - 1) ? 4'b1000 : 4'b0000;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cnt;
        logic [31:0] d;
        logic [3:0] raw;
        st = OL1; is_active = 1'b0;
        fv = 1'b1; fsop = 1'b1; feop = 1'b0; fd = 32'hAAAA0000; fk = 4'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst-tx", 64'(tx_data), 64'h00000000BC95B5B5);
        chk("rst-k", 64'(tx_datak), 64'h8);
        chk("rst-ready", 64'(frame_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        tick();
        chk("ol1-tx", 64'(tx_data), 64'h00000000BC358A55);
        chk("ol1-ready", 64'(frame_ready), 64'd0);
        st = OL2; tick();
        chk("ol2-tx", 64'(tx_data), 64'h00000000BC49BF49);
        st = LR2; tick();
        chk("lr2-tx", 64'(tx_data), 64'h00000000BC35BF49);
        st = LR3; tick();
        chk("lr3-tx", 64'(tx_data), 64'h00000000BC95B5B5);

        // Active entry, then two back-to-back 4-word frames
        st = AC; is_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 32'h11110000 + 32'(i);
            send_word(d, kof(i, 4), i == 0, i == 3, d, "f1", w);
            if (i == 0) chk("ac-holdoff", 64'(w), 64'd6);
        end
        for (int i = 0; i < 4; i++) begin
            d = 32'h22220000 + 32'(i);
            send_word(d, kof(i, 4), i == 0, i == 3, d, "f2", w);
            if (i == 0) begin
                chk("b2b-wait", 64'(w), 64'd6);
                chk("b2b-idles", 64'(last_run), 64'd6);
            end
        end
`ifdef FC_TX_STATS_EN
        chk("sent-2", 64'(frames_sent), 64'd2);
`endif

        // Source stalls for three cycles mid-frame
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                fv = 1'b0;
                repeat (3) tick();
            end
            d = 32'h33330000 + 32'(i);
            send_word(d, kof(i, 5), i == 0, i == 4, d, "f3", w);
            if (i == 3) chk("fill-idles", 64'(last_run), 64'd3);
        end

        // Link drops to LF1 on the second word of a 5-word frame
        for (int i = 0; i < 5; i++) begin
            d = 32'hD4D40000 + 32'(i);
            if (i == 1) st = LF1;
            send_word(d, kof(i, 5), i == 0, i == 4,
                      (i < 2) ? d : W_OLS, "f4", w);
            if (i >= 2) chk("drain-wait", 64'(w), 64'd0);
        end
        fv = 1'b0;
        tick();
        chk("abort-prim", 64'(tx_data), 64'h00000000BC358A55);
        chk("abort-leak", 64'(leak), 64'd0);
`ifdef FC_TX_STATS_EN
        chk("aborted-1", 64'(frames_aborted), 64'd1);
`endif
        st = LF2; tick();
        chk("lf2-tx", 64'(tx_data), 64'h00000000BC55BF45);
        raw = 4'hF;
        st = state_t'(raw); tick();
        chk("unknown-tx", 64'(tx_data), 64'h00000000BC358A55);

        // Active without holdoff complete: lane held in the gap
        st = AC; is_active = 1'b0;
        fd = 32'h55550000; fk = 4'b1000; fsop = 1'b1; feop = 1'b0; fv = 1'b1;
        cnt = 0;
        repeat (12) begin
            tick();
            if (frame_ready) cnt++;
        end
        chk("hold-inactive", 64'(cnt), 64'd0);
        is_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 32'h55550000 + 32'(i);
            if (i == 1) is_active = 1'b0;
            send_word(d, kof(i, 4), i == 0, i == 3, d, "f5", w);
            if (i == 0) chk("active-wait", 64'(w), 64'd1);
            if (i == 3) chk("finish-inactive", 64'(w), 64'd0);
        end
        fd = 32'h66660000; fsop = 1'b1; feop = 1'b0; fv = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick();
            if (frame_ready) cnt++;
        end
        chk("hold-after-frame", 64'(cnt), 64'd0);

        // eop accepted in the same cycle the link leaves AC
        is_active = 1'b1;
        send_word(32'h66660000, 4'b1000, 1'b1, 1'b0, 32'h66660000, "f6", w);
        st = OL1;
        send_word(32'h66660001, 4'b1000, 1'b0, 1'b1, 32'h66660001, "f6", w);
        fv = 1'b0;
        tick();
        chk("eop-leave-prim", 64'(tx_data), 64'h00000000BC358A55);
`ifdef FC_TX_STATS_EN
        chk("sent-5", 64'(frames_sent), 64'd5);
        chk("aborted-still-1", 64'(frames_aborted), 64'd1);
`endif

        // Word without sop while idle is dropped
        st = AC;
        send_word(32'hEEEE0000, 4'b0000, 1'b0, 1'b0, W_IDLE, "nosop", w);
        chk("nosop-wait", 64'(w), 64'd6);
        fv = 1'b0;
`ifdef FC_TX_STATS_EN
        chk("aborted-2", 64'(frames_aborted), 64'd2);
`endif

        // Asynchronous reset in the middle of a frame
        send_word(32'h77770000, 4'b1000, 1'b1, 1'b0, 32'h77770000, "f7", w);
        send_word(32'h77770001, 4'b0000, 1'b0, 1'b0, 32'h77770001, "f7", w);
        fd = 32'h77770002; fsop = 1'b0; fv = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("arst-tx", 64'(tx_data), 64'h00000000BC95B5B5);
        chk("arst-k", 64'(tx_datak), 64'h8);
        chk("arst-ready", 64'(frame_ready), 64'd0);
`ifdef FC_TX_STATS_EN
        chk("arst-sent", 64'(frames_sent), 64'd0);
        chk("arst-abort", 64'(frames_aborted), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        fv = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
